// File: rtl/elevator_core_if.sv
// Signal bundle between the elevator control core and its surroundings:
// floor sensors, hall calls and cabin buttons in, motor/door/monitor out.
interface elevator_core_if;
   logic       S1, S2, S3, S4;
   logic       U1, U2, U3, U4;
   logic       D1, D2, D3, D4;
   logic       F1, F2, F3, F4;
   logic       up;
   logic       down;
   logic       stop;
   logic [1:0] monitor;
   logic       open_door;

   // Environment side: drives sensors and buttons, watches the motor commands.
   modport master (
      output S1, S2, S3, S4,
      output U1, U2, U3, U4,
      output D1, D2, D3, D4,
      output F1, F2, F3, F4,
      input  up, down, stop, monitor, open_door
   );

   // Control-core side.
   modport slave (
      input  S1, S2, S3, S4,
      input  U1, U2, U3, U4,
      input  D1, D2, D3, D4,
      input  F1, F2, F3, F4,
      output up, down, stop, monitor, open_door
   );
endinterface

// File: rtl/elevator_core.sv
// Four-floor elevator control core. Latches hall and cabin calls, tracks the
// current floor from the level sensors and sequences the car through
// IDLE / UP / DOWN / DOOR with registered Moore outputs.
module elevator_core #(
   parameter int DOOR_CYCLES = 2
) (
   input logic            clk,
   input logic            reset,
   elevator_core_if.slave elevBus
);

   localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DOOR = 2'd3
   } state_t;

   // Floors strictly above n.
   function automatic logic [3:0] aboveMask(input logic [1:0] n);
      return 4'b1110 << n;
   endfunction

   // Floors strictly below n.
   function automatic logic [3:0] belowMask(input logic [1:0] n);
      logic [3:0] atOrAbove;
      atOrAbove = 4'b1111 << n;
      return ~atOrAbove;
   endfunction

   state_t           r_state;
   logic [1:0]       r_curFloor;
   logic [3:0]       r_hup;
   logic [3:0]       r_hdn;
   logic [3:0]       r_cab;
   logic [CNT_W-1:0] r_doorCnt;
   logic             r_dirUp;
   logic             r_up;
   logic             r_down;
   logic             r_stop;
   logic             r_openDoor;

   state_t           w_nextState;
   logic [3:0]       w_sensor;
   logic [3:0]       w_upCall;
   logic [3:0]       w_dnCall;
   logic [3:0]       w_cabCall;
   logic             w_atFloor;
   logic [1:0]       w_sensorIdx;
   logic [3:0]       w_pending;
   logic             w_reqAboveSensor;
   logic             w_reqBelowSensor;
   logic             w_reqAboveCur;
   logic             w_reqBelowCur;
   logic             w_doorEntry;
   logic [1:0]       w_doorFloor;
   logic             w_entryDirUp;
   logic             w_nextDirUp;
   logic             w_beyond;
   logic [3:0]       w_floorMask;
   logic [3:0]       w_ignoreMask;
   logic [3:0]       w_clrHup;
   logic [3:0]       w_clrHdn;
   logic [3:0]       w_clrCab;

   assign w_sensor  = {elevBus.S4, elevBus.S3, elevBus.S2, elevBus.S1};
   assign w_upCall  = {elevBus.U4, elevBus.U3, elevBus.U2, elevBus.U1};
   assign w_dnCall  = {elevBus.D4, elevBus.D3, elevBus.D2, elevBus.D1};
   assign w_cabCall = {elevBus.F4, elevBus.F3, elevBus.F2, elevBus.F1};
   assign w_atFloor = |w_sensor;
   assign w_pending = r_hup | r_hdn | r_cab;

   assign w_reqAboveSensor = |(w_pending & aboveMask(w_sensorIdx));
   assign w_reqBelowSensor = |(w_pending & belowMask(w_sensorIdx));
   assign w_reqAboveCur    = |(w_pending & aboveMask(r_curFloor));
   assign w_reqBelowCur    = |(w_pending & belowMask(r_curFloor));

   assign elevBus.up        = r_up;
   assign elevBus.down      = r_down;
   assign elevBus.stop      = r_stop;
   assign elevBus.monitor   = r_curFloor;
   assign elevBus.open_door = r_openDoor;

   // Resolve which floor the car is level with; the lowest active sensor wins
   // if several read high at once.
   always_comb begin
      w_sensorIdx = 2'd0;
      if (w_sensor[0]) begin
         w_sensorIdx = 2'd0;
      end else if (w_sensor[1]) begin
         w_sensorIdx = 2'd1;
      end else if (w_sensor[2]) begin
         w_sensorIdx = 2'd2;
      end else if (w_sensor[3]) begin
         w_sensorIdx = 2'd3;
      end
   end

   // Next-state selection, plus the floor and direction used when a stop begins.
   always_comb begin
      w_nextState  = r_state;
      w_nextDirUp  = r_dirUp;
      w_doorEntry  = 1'b0;
      w_doorFloor  = w_sensorIdx;
      w_entryDirUp = r_dirUp;
      case (r_state)
         IDLE: begin
            if (w_pending[r_curFloor] && w_sensor[r_curFloor]) begin
               w_nextState = DOOR;
               w_doorEntry = 1'b1;
               w_doorFloor = r_curFloor;
            end else if (w_reqAboveCur) begin
               w_nextState = UP;
               w_nextDirUp = 1'b1;
            end else if (w_reqBelowCur) begin
               w_nextState = DOWN;
               w_nextDirUp = 1'b0;
            end
         end
         UP: begin
            if (w_atFloor && (r_cab[w_sensorIdx] || r_hup[w_sensorIdx] ||
                              (r_hdn[w_sensorIdx] && !w_reqAboveSensor) ||
                              (w_sensorIdx == 2'd3))) begin
               w_nextState  = DOOR;
               w_doorEntry  = 1'b1;
               w_entryDirUp = 1'b1;
            end
         end
         DOWN: begin
            if (w_atFloor && (r_cab[w_sensorIdx] || r_hdn[w_sensorIdx] ||
                              (r_hup[w_sensorIdx] && !w_reqBelowSensor) ||
                              (w_sensorIdx == 2'd0))) begin
               w_nextState  = DOOR;
               w_doorEntry  = 1'b1;
               w_entryDirUp = 1'b0;
            end
         end
         DOOR: begin
            if (r_doorCnt == '0) begin
               if (r_dirUp) begin
                  if (w_reqAboveCur) begin
                     w_nextState = UP;
                  end else if (w_reqBelowCur) begin
                     w_nextState = DOWN;
                     w_nextDirUp = 1'b0;
                  end else begin
                     w_nextState = IDLE;
                  end
               end else begin
                  if (w_reqBelowCur) begin
                     w_nextState = DOWN;
                  end else if (w_reqAboveCur) begin
                     w_nextState = UP;
                     w_nextDirUp = 1'b1;
                  end else begin
                     w_nextState = IDLE;
                  end
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Work out which latches a stop serves. Floor 4 and floor 1 calls have no
   // useful direction there, so both hall latches at the end floors go together.
   always_comb begin
      w_floorMask  = 4'b0001 << w_doorFloor;
      w_beyond     = w_entryDirUp ? |(w_pending & aboveMask(w_doorFloor))
                                  : |(w_pending & belowMask(w_doorFloor));
      w_clrCab     = 4'b0000;
      w_clrHup     = 4'b0000;
      w_clrHdn     = 4'b0000;
      w_ignoreMask = 4'b0000;
      if (w_doorEntry) begin
         w_clrCab = w_floorMask;
         if (w_entryDirUp || !w_beyond || (w_doorFloor == 2'd3)) begin
            w_clrHup = w_floorMask;
         end
         if (!w_entryDirUp || !w_beyond || (w_doorFloor == 2'd0)) begin
            w_clrHdn = w_floorMask;
         end
      end
      if (r_state == DOOR) begin
         w_ignoreMask = 4'b0001 << r_curFloor;
      end
   end

   // Request latches: set by any button press, cleared when the car stops to
   // serve them; presses at the open-door floor are dropped so the door
   // cannot be held in a re-open loop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hup <= 4'b0000;
         r_hdn <= 4'b0000;
         r_cab <= 4'b0000;
      end else begin
         r_hup <= (r_hup | (w_upCall & ~w_ignoreMask)) & ~w_clrHup;
         r_hdn <= (r_hdn | (w_dnCall & ~w_ignoreMask)) & ~w_clrHdn;
         r_cab <= (r_cab | (w_cabCall & ~w_ignoreMask)) & ~w_clrCab;
      end
   end

   // Current floor follows the level sensors and holds between floors.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_curFloor <= 2'd0;
      end else if (w_atFloor) begin
         r_curFloor <= w_sensorIdx;
      end
   end

   // State register, door timer and registered motor/door outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_dirUp    <= 1'b1;
         r_doorCnt  <= '0;
         r_up       <= 1'b0;
         r_down     <= 1'b0;
         r_stop     <= 1'b1;
         r_openDoor <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_dirUp <= w_nextDirUp;
         if (w_doorEntry) begin
            r_doorCnt <= CNT_W'(DOOR_CYCLES - 1);
         end else if ((r_state == DOOR) && (r_doorCnt != '0)) begin
            r_doorCnt <= r_doorCnt - CNT_W'(1);
         end
         r_up       <= (w_nextState == UP);
         r_down     <= (w_nextState == DOWN);
         r_stop     <= (w_nextState == IDLE) || (w_nextState == DOOR);
         r_openDoor <= (w_nextState == DOOR);
      end
   end

endmodule

// File: tb/tb_elevator_core.sv
// Directed and randomized bench for the four-floor elevator core. A simple
// car model moves the floor sensors; expectations come from trip geometry.
module tb_elevator_core;

   localparam int DOOR_CYCLES = 2;

   // Expected {up, down, stop, open_door} for each kind of car activity.
   localparam logic [3:0] MOT_IDLE = 4'b0010;
   localparam logic [3:0] MOT_UP   = 4'b1000;
   localparam logic [3:0] MOT_DOWN = 4'b0100;
   localparam logic [3:0] MOT_DOOR = 4'b0011;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   modelFloor;

   elevator_core_if elevBus ();

   elevator_core #(
      .DOOR_CYCLES(DOOR_CYCLES)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .elevBus (elevBus)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic setSensorMask(input logic [3:0] mask);
      elevBus.S1 = mask[0];
      elevBus.S2 = mask[1];
      elevBus.S3 = mask[2];
      elevBus.S4 = mask[3];
   endtask

   // floor < 0 means the car is between floors.
   task automatic setSensor(input int floor);
      logic [3:0] mask;
      mask = 4'b0000;
      if (floor >= 0) mask[floor] = 1'b1;
      setSensorMask(mask);
   endtask

   task automatic applyStimulus(input logic [3:0] hallUp, input logic [3:0] hallDown,
                                input logic [3:0] cabin);
      {elevBus.U4, elevBus.U3, elevBus.U2, elevBus.U1} = hallUp;
      {elevBus.D4, elevBus.D3, elevBus.D2, elevBus.D1} = hallDown;
      {elevBus.F4, elevBus.F3, elevBus.F2, elevBus.F1} = cabin;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkMotor(input string tag, input logic [3:0] expMotor, input int expFloor);
      checkOutput({tag, "_motor"},
                  {elevBus.up, elevBus.down, elevBus.stop, elevBus.open_door}, expMotor);
      checkOutput({tag, "_monitor"}, {2'b00, elevBus.monitor}, 4'(expFloor));
   endtask

   // Sensor model: lowest floor reading high, or the previous floor if none.
   function automatic int lowestFloor(input logic [3:0] mask, input int previous);
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) previous = i;
      end
      return previous;
   endfunction

   initial begin
      int         target;
      int         kind;
      int         step;
      int         gap;
      int         lastFloor;
      logic       seen;
      logic [3:0] callVec;
      logic [3:0] expDir;
      logic [3:0] mask;

      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      setSensor(-1);
      applyStimulus(4'b0000, 4'b0000, 4'b0000);

      // 1) Reset held low for two cycles, then released.
      tick();
      tick();
      checkMotor("t1_inReset", MOT_IDLE, 0);
      reset = 1'b1;
      tick();
      checkMotor("t1_afterRelease", MOT_IDLE, 0);

      // 2) At floor 1, U2 pressed and held; car must start up within 2 cycles.
      setSensor(0);
      tick();
      applyStimulus(4'b0010, 4'b0000, 4'b0000);
      seen = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         if (elevBus.up === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("t2_upWithin2", {3'b000, seen}, 4'b0001);
      setSensor(-1);
      repeat (3) begin
         tick();
         checkMotor("t2_betweenFloors", MOT_UP, 0);
      end

      // 3) Arrive at floor 2 with U2 still held through the whole stop.
      setSensor(1);
      tick();
      checkMotor("t3_arrive", MOT_DOOR, 1);
      repeat (DOOR_CYCLES - 1) begin
         tick();
         checkMotor("t3_doorOpen", MOT_DOOR, 1);
      end
      tick();
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkMotor("t3_doorClosed", MOT_IDLE, 1);
      repeat (3) begin
         tick();
         checkMotor("t3_noReopen", MOT_IDLE, 1);
      end

      // 4) D3 and D4 pressed at floor 2: pass floor 3, stop at floor 4.
      applyStimulus(4'b0000, 4'b1100, 4'b0000);
      tick();
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      tick();
      checkMotor("t4_depart", MOT_UP, 1);
      setSensor(-1);
      tick();
      checkMotor("t4_gap1", MOT_UP, 1);
      setSensor(2);
      tick();
      checkMotor("t4_passFloor3", MOT_UP, 2);
      setSensor(-1);
      tick();
      checkMotor("t4_gap2", MOT_UP, 2);
      setSensor(3);
      tick();
      checkMotor("t4_arriveTop", MOT_DOOR, 3);
      repeat (DOOR_CYCLES - 1) begin
         tick();
         checkMotor("t4_doorOpen", MOT_DOOR, 3);
      end

      // 5) Door closes at floor 4 and the car reverses to serve D3.
      tick();
      checkMotor("t5_reverse", MOT_DOWN, 3);
      setSensor(-1);
      tick();
      checkMotor("t5_gap", MOT_DOWN, 3);
      setSensor(2);
      tick();
      checkMotor("t5_arrive", MOT_DOOR, 2);
      repeat (DOOR_CYCLES - 1) begin
         tick();
         checkMotor("t5_doorOpen", MOT_DOOR, 2);
      end
      tick();
      checkMotor("t5_idle", MOT_IDLE, 2);
      modelFloor = 2;

      // Random sensor patterns while idle: monitor follows the lowest sensor.
      for (int i = 0; i < 20; i++) begin
         mask = 4'($urandom_range(0, 15));
         setSensorMask(mask);
         tick();
         modelFloor = lowestFloor(mask, modelFloor);
         checkMotor("rnd_sensor", MOT_IDLE, modelFloor);
      end
      setSensor(modelFloor);
      tick();
      checkMotor("rnd_settle", MOT_IDLE, modelFloor);

      // Random single-call trips from the current floor to a random target.
      for (int trip = 0; trip < 8; trip++) begin
         target = $urandom_range(0, 3);
         if (target == modelFloor) target = (target + 1) % 4;
         kind    = $urandom_range(0, 2);
         callVec = 4'b0001 << target;
         expDir  = (target > modelFloor) ? MOT_UP : MOT_DOWN;
         step    = (target > modelFloor) ? 1 : -1;
         case (kind)
            0:       applyStimulus(4'b0000, 4'b0000, callVec);
            1:       applyStimulus(callVec, 4'b0000, 4'b0000);
            default: applyStimulus(4'b0000, callVec, 4'b0000);
         endcase
         tick();
         applyStimulus(4'b0000, 4'b0000, 4'b0000);
         checkMotor("trip_latched", MOT_IDLE, modelFloor);
         tick();
         checkMotor("trip_depart", expDir, modelFloor);
         lastFloor = modelFloor;
         for (int fl = modelFloor + step; fl != target; fl += step) begin
            gap = $urandom_range(1, 3);
            setSensor(-1);
            repeat (gap) begin
               tick();
               checkMotor("trip_gap", expDir, lastFloor);
            end
            setSensor(fl);
            tick();
            checkMotor("trip_pass", expDir, fl);
            lastFloor = fl;
         end
         gap = $urandom_range(1, 3);
         setSensor(-1);
         repeat (gap) begin
            tick();
            checkMotor("trip_gap", expDir, lastFloor);
         end
         setSensor(target);
         tick();
         checkMotor("trip_arrive", MOT_DOOR, target);
         repeat (DOOR_CYCLES - 1) begin
            tick();
            checkMotor("trip_doorOpen", MOT_DOOR, target);
         end
         tick();
         checkMotor("trip_idle", MOT_IDLE, target);
         modelFloor = target;
      end

      // 6) Reset asserted while moving up: immediate stop, calls discarded.
      setSensor(0);
      tick();
      applyStimulus(4'b0100, 4'b0000, 4'b1000);
      tick();
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      tick();
      checkMotor("t6_moving", MOT_UP, 0);
      setSensor(-1);
      tick();
      #2;
      reset = 1'b0;
      #1;
      checkMotor("t6_asyncReset", MOT_IDLE, 0);
      @(negedge clk);
      tick();
      reset = 1'b1;
      setSensor(0);
      repeat (4) begin
         tick();
         checkMotor("t6_callsGone", MOT_IDLE, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
